mouse_master_ctrl_p: RTL and testbench



---
 rtl/mouse_master_ctrl_p.sv | 338 +++++++++++++++++++++++++++++++++
 tb/tb_mouse_master_ctrl_p.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mouse_master_ctrl_p.sv
// PS/2 mouse host controller.
// Runs the init sequence: reset, optional IntelliMouse knock, rate/resolution, enable.
// Failed attempts are retried a bounded number of times.
// Once streaming, it assembles 3- or 4-byte packets in shadow registers and publishes
// each packet atomically with a one-cycle interrupt.
module mouse_master_ctrl_p #(
    parameter int unsigned INIT_WAIT_CYCLES    = 5000000,
    parameter int unsigned RESP_TIMEOUT_CYCLES = 2000000,
    parameter int unsigned MAX_RETRIES         = 3,
    parameter bit          EXT_MODE_EN         = 1'b1,
    parameter logic [7:0]  SAMPLE_RATE         = 8'd100,
    parameter logic [7:0]  RESOLUTION          = 8'd2
) (
    input  logic       CLK,
    input  logic       RESET,
    output logic       SEND_BYTE,
    output logic [7:0] BYTE_TO_SEND,
    input  logic       BYTE_SENT,
    output logic       READ_ENABLE,
    input  logic [7:0] BYTE_READ,
    input  logic [1:0] BYTE_ERROR_CODE,
    input  logic       BYTE_READY,
    output logic [7:0] MOUSE_STATUS,
    output logic [7:0] MOUSE_DX,
    output logic [7:0] MOUSE_DY,
    output logic [7:0] MOUSE_DZ,
    output logic       SEND_INTERRUPT,
    output logic       INTELLI_MODE,
    output logic       STREAMING,
    output logic       INIT_FAIL,
    output logic [3:0] RETRY_COUNT,
    output logic [7:0] RESYNC_COUNT,
    output logic [5:0] STATE_CODE
);

    typedef enum logic [5:0] {
        StInitWait = 6'd0,
        StSend     = 6'd1,
        StWaitSent = 6'd2,
        StWaitAck  = 6'd3,
        StWaitAa   = 6'd4,
        StWaitId0  = 6'd5,
        StReadId   = 6'd6,
        StB0       = 6'd7,
        StB1       = 6'd8,
        StB2       = 6'd9,
        StB3       = 6'd10,
        StCommit   = 6'd11,
        StFail     = 6'd12
    } state_e;

    // Command table indices: 0 = reset, 1..7 = knock + F2, 8..12 = final config.
    localparam logic [3:0]  IdxKnock     = 4'd1;
    localparam logic [3:0]  IdxGetId     = 4'd7;
    localparam logic [3:0]  IdxConfig    = 4'd8;
    localparam logic [3:0]  IdxLast      = 4'd12;
    localparam logic [3:0]  MaxRetries   = 4'(MAX_RETRIES);
    localparam logic [31:0] InitWaitLast = 32'(INIT_WAIT_CYCLES - 1);
    localparam logic [31:0] RespLast     = 32'(RESP_TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [31:0] timer_q, timer_d;
    logic [3:0]  cmd_idx_q, cmd_idx_d;
    logic [3:0]  retry_q, retry_d;
    logic [7:0]  resync_q, resync_d;
    logic        intelli_q, intelli_d;
    logic        streaming_q, streaming_d;
    logic        init_fail_q, init_fail_d;
    logic        send_q, send_d;
    logic [7:0]  tx_q, tx_d;
    logic        irq_q, irq_d;
    logic [7:0]  sh0_q, sh0_d, sh1_q, sh1_d, sh2_q, sh2_d, sh3_q, sh3_d;
    logic [7:0]  status_q, status_d, dx_q, dx_d, dy_q, dy_d, dz_q, dz_d;

    logic rx_ok;
    logic rx_bad;
    logic timed_out;
    logic counting;
    logic init_err;
    logic stream_err;
    logic resync_inc;

    function automatic logic [7:0] cmd_byte(input logic [3:0] idx);
        case (idx)
            4'd0:    cmd_byte = 8'hFF;
            4'd1:    cmd_byte = 8'hF3;
            4'd2:    cmd_byte = 8'hC8;
            4'd3:    cmd_byte = 8'hF3;
            4'd4:    cmd_byte = 8'h64;
            4'd5:    cmd_byte = 8'hF3;
            4'd6:    cmd_byte = 8'h50;
            4'd7:    cmd_byte = 8'hF2;
            4'd8:    cmd_byte = 8'hF3;
            4'd9:    cmd_byte = SAMPLE_RATE;
            4'd10:   cmd_byte = 8'hE8;
            4'd11:   cmd_byte = RESOLUTION;
            4'd12:   cmd_byte = 8'hF4;
            default: cmd_byte = 8'hFF;
        endcase
    endfunction

    assign rx_ok     = BYTE_READY && (BYTE_ERROR_CODE == 2'b00);
    assign rx_bad    = BYTE_READY && (BYTE_ERROR_CODE != 2'b00);
    assign timed_out = (timer_q >= RespLast);
    assign counting  = state_q inside {StInitWait, StWaitSent, StWaitAck, StWaitAa, StWaitId0,
                                       StReadId, StB1, StB2, StB3};

    // Next-state, handshake and packet assembly logic.
    always_comb begin
        state_d     = state_q;
        cmd_idx_d   = cmd_idx_q;
        retry_d     = retry_q;
        resync_d    = resync_q;
        intelli_d   = intelli_q;
        streaming_d = streaming_q;
        init_fail_d = init_fail_q;
        send_d      = 1'b0;
        tx_d        = tx_q;
        irq_d       = 1'b0;
        sh0_d       = sh0_q;
        sh1_d       = sh1_q;
        sh2_d       = sh2_q;
        sh3_d       = sh3_q;
        status_d    = status_q;
        dx_d        = dx_q;
        dy_d        = dy_q;
        dz_d        = dz_q;
        init_err    = 1'b0;
        stream_err  = 1'b0;
        resync_inc  = 1'b0;

        unique case (state_q)
            StInitWait: if (timer_q >= InitWaitLast) state_d = StSend;
            StSend: begin
                send_d  = 1'b1;
                tx_d    = cmd_byte(cmd_idx_q);
                state_d = StWaitSent;
            end
            StWaitSent: begin
                if (BYTE_SENT)      state_d = StWaitAck;
                else if (timed_out) init_err = 1'b1;
            end
            StWaitAck: begin
                if (BYTE_READY) begin
                    if (rx_ok && BYTE_READ == 8'hFA) begin
                        if (cmd_idx_q == 4'd0) begin
                            state_d = StWaitAa;
                        end else if (cmd_idx_q == IdxGetId) begin
                            state_d = StReadId;
                        end else if (cmd_idx_q == IdxLast) begin
                            state_d     = StB0;
                            streaming_d = 1'b1;
                            retry_d     = 4'd0;
                        end else begin
                            cmd_idx_d = cmd_idx_q + 4'd1;
                            state_d   = StSend;
                        end
                    end else begin
                        init_err = 1'b1;
                    end
                end else if (timed_out) begin
                    init_err = 1'b1;
                end
            end
            StWaitAa: begin
                if (BYTE_READY) begin
                    if (rx_ok && BYTE_READ == 8'hAA) state_d = StWaitId0;
                    else                             init_err = 1'b1;
                end else if (timed_out) begin
                    init_err = 1'b1;
                end
            end
            StWaitId0: begin
                if (BYTE_READY) begin
                    if (rx_ok && BYTE_READ == 8'h00) begin
                        cmd_idx_d = EXT_MODE_EN ? IdxKnock : IdxConfig;
                        state_d   = StSend;
                    end else begin
                        init_err = 1'b1;
                    end
                end else if (timed_out) begin
                    init_err = 1'b1;
                end
            end
            StReadId: begin
                if (BYTE_READY) begin
                    if (rx_ok && (BYTE_READ == 8'h03 || BYTE_READ == 8'h00)) begin
                        intelli_d = (BYTE_READ == 8'h03);
                        cmd_idx_d = IdxConfig;
                        state_d   = StSend;
                    end else begin
                        init_err = 1'b1;
                    end
                end else if (timed_out) begin
                    init_err = 1'b1;
                end
            end
            // B0 has no gap timeout: an idle mouse sends nothing.
            StB0: begin
                if (rx_bad) begin
                    stream_err = 1'b1;
                end else if (BYTE_READY) begin
                    if (BYTE_READ[3]) begin
                        sh0_d   = BYTE_READ;
                        state_d = StB1;
                    end else begin
                        resync_inc = 1'b1;
                    end
                end
            end
            StB1, StB2, StB3: begin
                if (rx_bad) begin
                    stream_err = 1'b1;
                end else if (BYTE_READY) begin
                    if (state_q == StB1) begin
                        sh1_d   = BYTE_READ;
                        state_d = StB2;
                    end else if (state_q == StB2) begin
                        sh2_d   = BYTE_READ;
                        state_d = intelli_q ? StB3 : StCommit;
                    end else begin
                        sh3_d   = BYTE_READ;
                        state_d = StCommit;
                    end
                end else if (timed_out) begin
                    resync_inc = 1'b1;
                    state_d    = StB0;
                end
            end
            StCommit: begin
                status_d = sh0_q;
                dx_d     = sh1_q;
                dy_d     = sh2_q;
                dz_d     = intelli_q ? sh3_q : 8'h00;
                irq_d    = 1'b1;
                state_d  = StB0;
            end
            StFail: state_d = StFail;
            default: begin
                state_d     = StInitWait;
                cmd_idx_d   = 4'd0;
                retry_d     = 4'd0;
                intelli_d   = 1'b0;
                streaming_d = 1'b0;
            end
        endcase

        if (init_err) begin
            retry_d   = retry_q + 4'd1;
            cmd_idx_d = 4'd0;
            intelli_d = 1'b0;
            if (retry_d < MaxRetries) begin
                state_d = StInitWait;
            end else begin
                state_d     = StFail;
                init_fail_d = 1'b1;
            end
        end

        // Line error while streaming means the link is suspect: full reinit.
        if (stream_err) begin
            state_d     = StInitWait;
            cmd_idx_d   = 4'd0;
            intelli_d   = 1'b0;
            streaming_d = 1'b0;
        end

        if (resync_inc && resync_q != 8'hFF) resync_d = resync_q + 8'd1;
    end

    // Shared wait/timeout counter, restarted on every state change.
    always_comb begin
        timer_d = 32'd0;
        if (counting && state_d == state_q) timer_d = timer_q + 32'd1;
    end

    // State and output registers.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= StInitWait;
            timer_q     <= 32'd0;
            cmd_idx_q   <= 4'd0;
            retry_q     <= 4'd0;
            resync_q    <= 8'd0;
            intelli_q   <= 1'b0;
            streaming_q <= 1'b0;
            init_fail_q <= 1'b0;
            send_q      <= 1'b0;
            tx_q        <= 8'h00;
            irq_q       <= 1'b0;
            sh0_q       <= 8'h00;
            sh1_q       <= 8'h00;
            sh2_q       <= 8'h00;
            sh3_q       <= 8'h00;
            status_q    <= 8'h00;
            dx_q        <= 8'h00;
            dy_q        <= 8'h00;
            dz_q        <= 8'h00;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            cmd_idx_q   <= cmd_idx_d;
            retry_q     <= retry_d;
            resync_q    <= resync_d;
            intelli_q   <= intelli_d;
            streaming_q <= streaming_d;
            init_fail_q <= init_fail_d;
            send_q      <= send_d;
            tx_q        <= tx_d;
            irq_q       <= irq_d;
            sh0_q       <= sh0_d;
            sh1_q       <= sh1_d;
            sh2_q       <= sh2_d;
            sh3_q       <= sh3_d;
            status_q    <= status_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            dz_q        <= dz_d;
        end
    end

    assign SEND_BYTE      = send_q;
    assign BYTE_TO_SEND   = tx_q;
    assign READ_ENABLE    = state_q inside {StWaitAck, StWaitAa, StWaitId0, StReadId,
                                            StB0, StB1, StB2, StB3};
    assign MOUSE_STATUS   = status_q;
    assign MOUSE_DX       = dx_q;
    assign MOUSE_DY       = dy_q;
    assign MOUSE_DZ       = dz_q;
    assign SEND_INTERRUPT = irq_q;
    assign INTELLI_MODE   = intelli_q;
    assign STREAMING      = streaming_q;
    assign INIT_FAIL      = init_fail_q;
    assign RETRY_COUNT    = retry_q;
    assign RESYNC_COUNT   = resync_q;
    assign STATE_CODE     = state_q;

endmodule

// File: tb/tb_mouse_master_ctrl_p.sv
// Directed bench: DUT 0 has the IntelliMouse knock enabled, DUT 1 does not. Both share the
// same mouse-side stimulus; `sel` picks which one the checks look at.
`timescale 1ns/1ps
module tb_mouse_master_ctrl_p;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       byte_sent = 1'b0;
    logic       byte_ready = 1'b0;
    logic [7:0] byte_read = 8'h00;
    logic [1:0] byte_err = 2'b00;
    logic       sel = 1'b0;

    logic       send_w    [2];
    logic [7:0] tx_w      [2];
    logic       re_w      [2];
    logic [7:0] st_w      [2];
    logic [7:0] dx_w      [2];
    logic [7:0] dy_w      [2];
    logic [7:0] dz_w      [2];
    logic       irq_w     [2];
    logic       intelli_w [2];
    logic       stream_w  [2];
    logic       fail_w    [2];
    logic [3:0] retry_w   [2];
    logic [7:0] resync_w  [2];
    logic [5:0] state_w   [2];

    always #5 CLK = ~CLK;

    mouse_master_ctrl_p #(
        .INIT_WAIT_CYCLES(100), .RESP_TIMEOUT_CYCLES(1000), .MAX_RETRIES(3),
        .EXT_MODE_EN(1'b1), .SAMPLE_RATE(8'd100), .RESOLUTION(8'd2)
    ) dut_ext (
        .CLK(CLK), .RESET(RESET), .SEND_BYTE(send_w[0]), .BYTE_TO_SEND(tx_w[0]),
        .BYTE_SENT(byte_sent), .READ_ENABLE(re_w[0]), .BYTE_READ(byte_read),
        .BYTE_ERROR_CODE(byte_err), .BYTE_READY(byte_ready), .MOUSE_STATUS(st_w[0]),
        .MOUSE_DX(dx_w[0]), .MOUSE_DY(dy_w[0]), .MOUSE_DZ(dz_w[0]),
        .SEND_INTERRUPT(irq_w[0]), .INTELLI_MODE(intelli_w[0]), .STREAMING(stream_w[0]),
        .INIT_FAIL(fail_w[0]), .RETRY_COUNT(retry_w[0]), .RESYNC_COUNT(resync_w[0]),
        .STATE_CODE(state_w[0])
    );

    mouse_master_ctrl_p #(
        .INIT_WAIT_CYCLES(100), .RESP_TIMEOUT_CYCLES(1000), .MAX_RETRIES(3),
        .EXT_MODE_EN(1'b0), .SAMPLE_RATE(8'd100), .RESOLUTION(8'd2)
    ) dut_std (
        .CLK(CLK), .RESET(RESET), .SEND_BYTE(send_w[1]), .BYTE_TO_SEND(tx_w[1]),
        .BYTE_SENT(byte_sent), .READ_ENABLE(re_w[1]), .BYTE_READ(byte_read),
        .BYTE_ERROR_CODE(byte_err), .BYTE_READY(byte_ready), .MOUSE_STATUS(st_w[1]),
        .MOUSE_DX(dx_w[1]), .MOUSE_DY(dy_w[1]), .MOUSE_DZ(dz_w[1]),
        .SEND_INTERRUPT(irq_w[1]), .INTELLI_MODE(intelli_w[1]), .STREAMING(stream_w[1]),
        .INIT_FAIL(fail_w[1]), .RETRY_COUNT(retry_w[1]), .RESYNC_COUNT(resync_w[1]),
        .STATE_CODE(state_w[1])
    );

    logic        m_send, m_re, m_irq, m_intelli, m_stream, m_fail;
    logic [7:0]  m_tx, m_resync;
    logic [3:0]  m_retry;
    logic [31:0] m_pkt;
    logic [63:0] m_all;

    assign m_send    = send_w[sel];
    assign m_tx      = tx_w[sel];
    assign m_re      = re_w[sel];
    assign m_irq     = irq_w[sel];
    assign m_intelli = intelli_w[sel];
    assign m_stream  = stream_w[sel];
    assign m_fail    = fail_w[sel];
    assign m_retry   = retry_w[sel];
    assign m_resync  = resync_w[sel];
    assign m_pkt     = {st_w[sel], dx_w[sel], dy_w[sel], dz_w[sel]};
    assign m_all     = {m_send, m_tx, m_re, m_pkt, m_irq, m_intelli, m_stream, m_fail,
                        m_retry, m_resync, state_w[sel]};

    int checks = 0;
    int errors = 0;
    int irq_cnt = 0;
    int send_cnt = 0;

    // Running event counters; tests compare deltas.
    always @(negedge CLK) begin
        if (m_irq)  irq_cnt  <= irq_cnt + 1;
        if (m_send) send_cnt <= send_cnt + 1;
    end

    typedef struct {
        bit         is_cmd;
        logic [7:0] tx;
        logic [7:0] rx;
    } step_t;

    typedef struct {
        logic [31:0] bytes_in;
        logic [31:0] exp_out;
    } pkt_t;

    step_t tbl [2][16];
    int    tbl_len [2];
    pkt_t  pkts [3];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_step(input int t, input int i, input bit c, input logic [7:0] tx,
                            input logic [7:0] rx);
        tbl[t][i].is_cmd = c;
        tbl[t][i].tx     = tx;
        tbl[t][i].rx     = rx;
    endtask

    task automatic wait_send(input int budget, output logic [7:0] b, output int cyc);
        cyc = 0;
        b   = 8'h00;
        while (cyc < budget && !m_send) begin
            @(negedge CLK);
            cyc++;
        end
        if (!m_send) begin
            checks++;
            errors++;
            $display("FAIL send_wait: no SEND_BYTE within %0d cycles", budget);
        end else begin
            b = m_tx;
        end
    endtask

    task automatic pulse_sent();
        byte_sent = 1'b1;
        @(negedge CLK);
        byte_sent = 1'b0;
    endtask

    task automatic reply(input logic [7:0] b, input logic [1:0] e);
        byte_read  = b;
        byte_err   = e;
        byte_ready = 1'b1;
        @(negedge CLK);
        byte_ready = 1'b0;
        byte_err   = 2'b00;
    endtask

    // Play the first n steps of init table t as the mouse.
    task automatic run_init(input int t, input int n, output int first_cyc);
        logic [7:0] b;
        int         cyc;
        first_cyc = -1;
        for (int i = 0; i < n; i++) begin
            if (tbl[t][i].is_cmd) begin
                wait_send(3000, b, cyc);
                if (first_cyc < 0) first_cyc = cyc;
                check($sformatf("init%0d_tx%0d", t, i), b, tbl[t][i].tx);
                pulse_sent();
            end
            reply(tbl[t][i].rx, 2'b00);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        int         fc;
        int         k;
        int         i0;
        int         s0;
        logic [7:0] b;

        // IntelliMouse init (ID byte at index 10 is patched per test).
        set_step(0, 0, 1, 8'hFF, 8'hFA);  set_step(0, 1, 0, 8'h00, 8'hAA);
        set_step(0, 2, 0, 8'h00, 8'h00);  set_step(0, 3, 1, 8'hF3, 8'hFA);
        set_step(0, 4, 1, 8'hC8, 8'hFA);  set_step(0, 5, 1, 8'hF3, 8'hFA);
        set_step(0, 6, 1, 8'h64, 8'hFA);  set_step(0, 7, 1, 8'hF3, 8'hFA);
        set_step(0, 8, 1, 8'h50, 8'hFA);  set_step(0, 9, 1, 8'hF2, 8'hFA);
        set_step(0, 10, 0, 8'h00, 8'h03); set_step(0, 11, 1, 8'hF3, 8'hFA);
        set_step(0, 12, 1, 8'h64, 8'hFA); set_step(0, 13, 1, 8'hE8, 8'hFA);
        set_step(0, 14, 1, 8'h02, 8'hFA); set_step(0, 15, 1, 8'hF4, 8'hFA);
        tbl_len[0] = 16;
        // Knock disabled.
        set_step(1, 0, 1, 8'hFF, 8'hFA);  set_step(1, 1, 0, 8'h00, 8'hAA);
        set_step(1, 2, 0, 8'h00, 8'h00);  set_step(1, 3, 1, 8'hF3, 8'hFA);
        set_step(1, 4, 1, 8'h64, 8'hFA);  set_step(1, 5, 1, 8'hE8, 8'hFA);
        set_step(1, 6, 1, 8'h02, 8'hFA);  set_step(1, 7, 1, 8'hF4, 8'hFA);
        tbl_len[1] = 8;
        // 4-byte packets: {byte0..byte3} in, {STATUS,DX,DY,DZ} expected.
        pkts[0] = '{32'h0805FB01, 32'h0805FB01};
        pkts[1] = '{32'h18FF01FF, 32'h18FF01FF};
        pkts[2] = '{32'h2C807F0F, 32'h2C807F0F};

        // Reset values on both instances.
        repeat (3) @(negedge CLK);
        check("reset_all_ext", m_all, 64'd0);
        sel = 1'b1;
        #1;
        check("reset_all_std", m_all, 64'd0);
        sel = 1'b0;

        // Nominal IntelliMouse init and streaming.
        RESET = 1'b0;
        run_init(0, tbl_len[0], fc);
        check("first_ff_delay", fc, 101);
        check("intelli_streaming", m_stream, 1'b1);
        check("intelli_mode", m_intelli, 1'b1);
        check("intelli_retry", m_retry, 4'd0);
        for (int p = 0; p < 3; p++) begin
            i0 = irq_cnt;
            for (int j = 3; j >= 0; j--) begin
                b = pkts[p].bytes_in[j*8 +: 8];
                reply(b, 2'b00);
            end
            repeat (3) @(negedge CLK);
            check($sformatf("pkt%0d_out", p), m_pkt, pkts[p].exp_out);
            check($sformatf("pkt%0d_irq", p), irq_cnt - i0, 1);
        end

        // Line error on DX byte forces reinit; reset during the ID read.
        reply(8'h08, 2'b00);
        reply(8'h22, 2'b01);
        check("stream_err_streaming", m_stream, 1'b0);
        run_init(0, 10, fc);
        check("reinit_ff_delay", fc, 101);
        check("id_read_enable", m_re, 1'b1);
        RESET = 1'b1;
        @(negedge CLK);
        check("reset_mid_id", m_all, 64'd0);

        // Standard mouse (ID 00) on the knock-enabled instance.
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        tbl[0][10].rx = 8'h00;
        run_init(0, tbl_len[0], fc);
        check("std_intelli", m_intelli, 1'b0);
        check("std_streaming", m_stream, 1'b1);
        i0 = irq_cnt;
        reply(8'h09, 2'b00);
        reply(8'h10, 2'b00);
        check("std_no_early_irq", irq_cnt - i0, 0);
        reply(8'h20, 2'b00);
        repeat (3) @(negedge CLK);
        check("std_pkt_out", m_pkt, 32'h09102000);
        check("std_pkt_irq", irq_cnt - i0, 1);

        // Resync: bad sync byte, then a partial packet dropped by gap timeout.
        i0 = irq_cnt;
        reply(8'h00, 2'b00);
        check("resync_discard", m_resync, 8'd1);
        reply(8'h08, 2'b00);
        reply(8'h01, 2'b00);
        repeat (1010) @(negedge CLK);
        check("resync_gap", m_resync, 8'd2);
        check("resync_outputs_held", m_pkt, 32'h09102000);
        reply(8'h08, 2'b00);
        reply(8'h02, 2'b00);
        check("partial_outputs_held", m_pkt, 32'h09102000);
        reply(8'h03, 2'b00);
        repeat (3) @(negedge CLK);
        check("resync_pkt_out", m_pkt, 32'h08020300);
        check("resync_irq", irq_cnt - i0, 1);
        check("resync_final", m_resync, 8'd2);

        // Retry exhaustion: FE in reply to FF three times.
        RESET = 1'b1;
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        for (int r = 0; r < 3; r++) begin
            wait_send(3000, b, fc);
            check($sformatf("retry%0d_tx", r), b, 8'hFF);
            pulse_sent();
            reply(8'hFE, 2'b00);
            check($sformatf("retry%0d_count", r), m_retry, 4'(r + 1));
            check($sformatf("retry%0d_fail", r), m_fail, (r == 2));
        end
        s0 = send_cnt;
        repeat (10000) @(negedge CLK);
        check("fail_no_send", send_cnt - s0, 0);
        check("fail_read_enable", m_re, 1'b0);
        check("fail_sticky", m_fail, 1'b1);
        RESET = 1'b1;
        @(negedge CLK);
        check("fail_reset_all", m_all, 64'd0);

        // Withheld BYTE_SENT times out, then a good init clears the retry count.
        RESET = 1'b0;
        wait_send(3000, b, fc);
        check("timeout_tx", b, 8'hFF);
        k = 0;
        while (m_retry != 4'd1 && k < 2000) begin
            @(negedge CLK);
            k++;
        end
        check("timeout_cycles", k, 1000);
        check("timeout_not_fail", m_fail, 1'b0);
        tbl[0][10].rx = 8'h03;
        run_init(0, tbl_len[0], fc);
        check("recover_retry", m_retry, 4'd0);
        check("recover_streaming", m_stream, 1'b1);

        // Knock disabled instance: short sequence, never IntelliMouse.
        sel   = 1'b1;
        RESET = 1'b1;
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        run_init(1, tbl_len[1], fc);
        check("noext_ff_delay", fc, 101);
        check("noext_streaming", m_stream, 1'b1);
        check("noext_intelli", m_intelli, 1'b0);
        check("noext_retry", m_retry, 4'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
